// File: rtl/mcp3008_spi_responder.sv
// mcp3008_spi_responder
// SPI mode-0 slave that stands in for an MCP3008 8-channel ADC. It decodes the
// start / SGL / D2..D0 command from MOSI and reports it on cmd_*. It then returns
// the selected channel word on MISO with MCP3008 framing:
//   null bit, B9..B0 (MSB first), B1..B9 (LSB-first trailer), then zeros.
// The SPI pins are asynchronous to clk and are oversampled through 2-flop
// synchronizers, so every pin edge takes effect 3 clk edges after it happens.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   ch_value_flat  channel bank, channel n at [DATA_BITS*n +: DATA_BITS]
//   spi_sck        SPI clock (mode 0), asynchronous
//   spi_cs         chip select, active low, asynchronous
//   spi_mosi       command input
//   spi_miso       data output, forced to 0 while spi_miso_oe is 0
//   spi_miso_oe    drive enable for an external tri-state buffer
//   cmd_valid      one-cycle pulse on each completed command decode
//   cmd_channel    D2..D0 of the last decoded command
//   cmd_single     SGL/DIFF bit of the last decoded command (1 = single-ended)
module mcp3008_spi_responder #(
  parameter int DATA_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*DATA_BITS-1:0]   ch_value_flat,
  input  logic                     spi_sck,
  input  logic                     spi_cs,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_channel,
  output logic                     cmd_single
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_DISARMED   = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_CMD        = 3'd3;
  localparam logic [2:0] ST_NULL_BIT   = 3'd4;
  localparam logic [2:0] ST_MSB_OUT    = 3'd5;
  localparam logic [2:0] ST_LSB_OUT    = 3'd6;
  localparam logic [2:0] ST_TAIL       = 3'd7;

  // Channel bank viewed as an array of words.
  logic [DATA_BITS-1:0] ch_word [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch_word
      assign ch_word[gi] = ch_value_flat[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // Synchronizers, bit order {sck, cs, mosi}. They reset to 0 so that a chip
  // select that is already low when reset releases reads as "in a frame" and
  // the block stays disarmed until it has seen CS high.
  logic [2:0] sync_meta_reg;
  logic [2:0] sync_reg;
  logic       sck_prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta_reg <= 3'b000;
      sync_reg      <= 3'b000;
      sck_prev_reg  <= 1'b0;
    end else begin
      sync_meta_reg <= {spi_sck, spi_cs, spi_mosi};
      sync_reg      <= sync_meta_reg;
      sck_prev_reg  <= sync_reg[2];
    end
  end

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic rise;
  logic fall;

  assign sck_s  = sync_reg[2];
  assign cs_s   = sync_reg[1];
  assign mosi_s = sync_reg[0];
  assign rise   = sck_s & ~sck_prev_reg;
  assign fall   = ~sck_s & sck_prev_reg;

  logic [2:0]           state_reg;
  logic [CNT_W-1:0]     bit_cnt_reg;
  logic [3:0]           cmd_bits_reg;   // {SGL, D2, D1, D0} once complete
  logic [DATA_BITS-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_DISARMED;
      bit_cnt_reg  <= '0;
      cmd_bits_reg <= 4'd0;
      shift_reg    <= '0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_channel  <= 3'd0;
      cmd_single   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (cs_s) begin
        // CS high terminates any frame and takes priority over a same-cycle
        // SCK edge. From DISARMED this is also the arming condition.
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state_reg)
          ST_DISARMED: begin
            // Joined mid-frame: ignore everything until CS goes high.
          end
          ST_IDLE: begin
            state_reg <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (rise && mosi_s) begin
              state_reg    <= ST_CMD;
              bit_cnt_reg  <= '0;
              cmd_bits_reg <= 4'd0;
            end
          end
          ST_CMD: begin
            if (rise) begin
              cmd_bits_reg <= {cmd_bits_reg[2:0], mosi_s};
              if (bit_cnt_reg == CNT_W'(3)) begin
                state_reg   <= ST_NULL_BIT;
                bit_cnt_reg <= '0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
          ST_NULL_BIT: begin
            if (fall) begin
              // Differential mode reads the same slot; only cmd_single differs.
              shift_reg   <= ch_word[cmd_bits_reg[2:0]];
              spi_miso_oe <= 1'b1;
              spi_miso    <= 1'b0;
              cmd_channel <= cmd_bits_reg[2:0];
              cmd_single  <= cmd_bits_reg[3];
              cmd_valid   <= 1'b1;
              state_reg   <= ST_MSB_OUT;
              bit_cnt_reg <= '0;
            end
          end
          ST_MSB_OUT: begin
            if (fall) begin
              // Rotate rather than shift so the word is intact again for the
              // LSB-first trailer once all DATA_BITS bits have gone out.
              spi_miso  <= shift_reg[DATA_BITS-1];
              shift_reg <= {shift_reg[DATA_BITS-2:0], shift_reg[DATA_BITS-1]};
              if (bit_cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                state_reg   <= ST_LSB_OUT;
                bit_cnt_reg <= '0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
          ST_LSB_OUT: begin
            if (fall) begin
              // B0 is not repeated: emit bit 1 and rotate right, giving B1..B9.
              spi_miso  <= shift_reg[1];
              shift_reg <= {shift_reg[0], shift_reg[DATA_BITS-1:1]};
              if (bit_cnt_reg == CNT_W'(DATA_BITS - 2)) begin
                state_reg   <= ST_TAIL;
                bit_cnt_reg <= '0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
          ST_TAIL: begin
            if (fall) begin
              spi_miso <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_DISARMED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Testbench for mcp3008_spi_responder. It acts as an SPI master and records
// MISO / MISO-enable at every SCK rising edge. Each frame is compared with the
// MCP3008 framing computed from the channel bank. A per-cycle monitor checks
// the output rules: quiet MISO while the driver is off, cmd_valid coinciding
// with the enable rising, and the decoded command on every cmd_valid.
module tb_mcp3008_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [79:0] ch_flat;
  logic        spi_sck;
  logic        spi_cs;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        cmd_valid;
  logic [2:0]  cmd_channel;
  logic        cmd_single;

  mcp3008_spi_responder #(.DATA_BITS(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ch_value_flat (ch_flat),
    .spi_sck       (spi_sck),
    .spi_cs        (spi_cs),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .cmd_valid     (cmd_valid),
    .cmd_channel   (cmd_channel),
    .cmd_single    (cmd_single)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  logic [2:0] exp_ch = 3'd0;
  logic       exp_sgl = 1'b0;
  logic       late_upd = 1'b0;
  logic [9:0] ch_vals [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_flat();
    for (int n = 0; n < 8; n++) ch_flat[n*10 +: 10] = ch_vals[n];
  endtask

  // Per-cycle output monitor.
  initial begin : monitor
    logic oe_prev;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!spi_miso_oe) chk("miso_quiet", 32'(spi_miso), 32'd0);
      chk("valid_with_oe_rise", 32'(cmd_valid), 32'(spi_miso_oe & ~oe_prev));
      if (cmd_valid) begin
        valid_count++;
        chk("valid_channel", 32'(cmd_channel), 32'(exp_ch));
        chk("valid_single", 32'(cmd_single), 32'(exp_sgl));
        if (late_upd) ch_flat = ~ch_flat;
      end
      oe_prev = spi_miso_oe;
    end
  end

  // One SPI frame: lead zeros, start, SGL, D2..D0, then zeros up to nclk clocks.
  // abort_at >= 0 raises CS before clock number abort_at. Records MISO and the
  // enable just before each rising SCK edge (the master's sampling point).
  task automatic run_frame(input logic sgl, input logic [2:0] ch, input int lead,
                           input int nclk, input int half, input int abort_at,
                           output logic [63:0] mb, output logic [63:0] ob);
    logic [63:0] mosi_bits;
    mosi_bits = '0;
    mosi_bits[lead]     = 1'b1;
    mosi_bits[lead + 1] = sgl;
    mosi_bits[lead + 2] = ch[2];
    mosi_bits[lead + 3] = ch[1];
    mosi_bits[lead + 4] = ch[0];
    mb = '0;
    ob = '0;
    exp_ch  = ch;
    exp_sgl = sgl;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == abort_at) break;
      spi_mosi = mosi_bits[i];
      repeat (half) @(negedge clk);
      mb[i] = spi_miso;
      ob[i] = spi_miso_oe;
      spi_sck = 1'b1;
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
    end
    spi_mosi = 1'b0;
    repeat (half) @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("oe_off_after_cs", 32'(spi_miso_oe), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // MCP3008 framing relative to the start bit at position lead: nothing is
  // driven through D0, null bit at lead+5, B9..B0, then B1..B9, then zeros.
  task automatic check_stream(input string tag, input int lead, input int nclk,
                              input logic [9:0] val, input logic [63:0] mb,
                              input logic [63:0] ob);
    int v;
    int nb;
    logic em;
    logic eo;
    v  = int'(val);
    nb = lead + 5;
    for (int i = 0; i < nclk; i++) begin
      eo = (i >= nb);
      em = 1'b0;
      if (i >= nb + 1 && i <= nb + 10) em = 1'((v >> (9 - (i - nb - 1))) & 1);
      else if (i >= nb + 11 && i <= nb + 19) em = 1'((v >> (i - nb - 11 + 1)) & 1);
      chk($sformatf("%s bit%0d {oe,miso}", tag, i), 32'({ob[i], mb[i]}), 32'({eo, em}));
    end
  endtask

  function automatic logic [9:0] msb_word(input int lead, input logic [63:0] mb);
    logic [9:0] w;
    for (int k = 0; k < 10; k++) w[9 - k] = mb[lead + 6 + k];
    return w;
  endfunction

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete within the cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [63:0] mb;
    logic [63:0] ob;
    logic [8:0]  lsb;
    logic [9:0]  saved;
    int          vc;
    logic        sgl;
    logic [2:0]  ch;
    int          lead;
    int          half;
    int          extra;

    rst_n = 1'b0;
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    for (int n = 0; n < 8; n++) ch_vals[n] = 10'd0;
    set_flat();
    repeat (4) @(negedge clk);
    chk("reset miso", 32'(spi_miso), 32'd0);
    chk("reset oe", 32'(spi_miso_oe), 32'd0);
    chk("reset valid", 32'(cmd_valid), 32'd0);
    chk("reset channel", 32'(cmd_channel), 32'd0);
    chk("reset single", 32'(cmd_single), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single-ended read of ch0 with exactly 16 clocks.
    ch_vals[0] = 10'h2A5;
    set_flat();
    vc = valid_count;
    run_frame(1'b1, 3'd0, 0, 16, 5, -1, mb, ob);
    check_stream("se_ch0", 0, 16, 10'h2A5, mb, ob);
    chk("se_ch0 word", 32'(msb_word(0, mb)), 32'h2A5);
    chk("se_ch0 null", 32'({ob[5], mb[5]}), 32'b10);
    chk("se_ch0 pulses", 32'(valid_count - vc), 32'd1);
    chk("se_ch0 channel", 32'(cmd_channel), 32'd0);
    chk("se_ch0 single", 32'(cmd_single), 32'd1);

    // All channels, ch_n = 0x3FF - n.
    for (int n = 0; n < 8; n++) ch_vals[n] = 10'(10'h3FF - n);
    set_flat();
    for (int n = 0; n < 8; n++) begin
      vc = valid_count;
      run_frame(1'b1, 3'(n), 0, 25, 4, -1, mb, ob);
      check_stream($sformatf("all_ch%0d", n), 0, 25, ch_vals[n], mb, ob);
      chk($sformatf("all_ch%0d word", n), 32'(msb_word(0, mb)), 32'(10'h3FF - n));
      chk($sformatf("all_ch%0d channel", n), 32'(cmd_channel), 32'(n));
      chk($sformatf("all_ch%0d pulses", n), 32'(valid_count - vc), 32'd1);
    end

    // Leading zeros, full LSB-first trailer and extra trailing clocks.
    ch_vals[3] = 10'h155;
    set_flat();
    run_frame(1'b1, 3'd3, 3, 30, 5, -1, mb, ob);
    check_stream("lead_ch3", 3, 30, 10'h155, mb, ob);
    for (int k = 0; k < 9; k++) lsb[k] = mb[3 + 16 + k];
    chk("lead_ch3 lsb trailer", 32'(lsb), 32'h0AA);
    chk("lead_ch3 channel", 32'(cmd_channel), 32'd3);

    // Abort after D1, then a clean frame to ch5.
    vc = valid_count;
    run_frame(1'b1, 3'd5, 0, 25, 5, 4, mb, ob);
    chk("abort pulses", 32'(valid_count - vc), 32'd0);
    chk("abort channel kept", 32'(cmd_channel), 32'd3);
    ch_vals[5] = 10'h1C3;
    set_flat();
    run_frame(1'b1, 3'd5, 0, 25, 5, -1, mb, ob);
    check_stream("after_abort_ch5", 0, 25, 10'h1C3, mb, ob);
    chk("after_abort channel", 32'(cmd_channel), 32'd5);

    // Reset during MSB_OUT while CS stays low.
    fork
      run_frame(1'b1, 3'd5, 0, 25, 5, -1, mb, ob);
      begin
        repeat (96) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst oe", 32'(spi_miso_oe), 32'd0);
        chk("midrst miso", 32'(spi_miso), 32'd0);
        chk("midrst channel", 32'(cmd_channel), 32'd0);
        chk("midrst single", 32'(cmd_single), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    for (int i = 10; i < 25; i++)
      chk($sformatf("midrst silent bit%0d {oe,miso}", i), 32'({ob[i], mb[i]}), 32'd0);
    chk("midrst channel after", 32'(cmd_channel), 32'd0);
    vc = valid_count;
    run_frame(1'b1, 3'd2, 0, 25, 5, -1, mb, ob);
    check_stream("post_rst_ch2", 0, 25, ch_vals[2], mb, ob);
    chk("post_rst pulses", 32'(valid_count - vc), 32'd1);
    chk("post_rst channel", 32'(cmd_channel), 32'd2);

    // Differential read of ch6; the bank is inverted right after cmd_valid.
    saved = ch_vals[6];
    late_upd = 1'b1;
    run_frame(1'b0, 3'd6, 0, 25, 5, -1, mb, ob);
    late_upd = 1'b0;
    check_stream("diff_ch6", 0, 25, saved, mb, ob);
    chk("diff_ch6 single", 32'(cmd_single), 32'd0);
    chk("diff_ch6 channel", 32'(cmd_channel), 32'd6);
    set_flat();

    // Randomized frames.
    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < 8; n++) ch_vals[n] = 10'($urandom_range(0, 1023));
      set_flat();
      sgl   = 1'($urandom_range(0, 1));
      ch    = 3'($urandom_range(0, 7));
      lead  = int'($urandom_range(0, 3));
      half  = int'($urandom_range(4, 7));
      extra = int'($urandom_range(0, 3));
      vc = valid_count;
      run_frame(sgl, ch, lead, lead + 25 + extra, half, -1, mb, ob);
      check_stream($sformatf("rand%0d", t), lead, lead + 25 + extra, ch_vals[ch], mb, ob);
      chk($sformatf("rand%0d pulses", t), 32'(valid_count - vc), 32'd1);
      chk($sformatf("rand%0d channel", t), 32'(cmd_channel), 32'(ch));
      chk($sformatf("rand%0d single", t), 32'(cmd_single), 32'(sgl));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
